pe_shift_acc: RTL and testbench
===============================

// Module: pe_shift_acc
// PURPOSE
// - Shift-accumulate (SS) stage of the PE datapath: directly downstream of the Aunit multiplier.
// - Folds bit-serial Aunit partial products (AuODWd) into one psum per output pixel under SSctl.
// - Emits each finished psum, saturated to PSUMDWD, towards the psum pad / next PE.
// - Consumes psum init values read back from the psum pad.
// PARAMETERS
// - ACCWD   24        internal accumulator width, signed; must be >= PSUMDWD+8
// - PSUMDWD 16        output psum width, signed (PECfg::PSUMDWD)
// - AUWD    16        Aunit output width (PECtlCfg::AuODWd)
// PORTS
// - i_clk        in   1        clock
// - i_rst        in   1        async reset, active-low
// - i_clear      in   1        sync clear (Inst.reset); priority over every other input
// - i_stall      in   1        freeze all state; no handshakes complete
// - i_tw         in   7        pixels per row (Conf.Tw), 1..127, sampled while IDLE
// - i_valid      in   1        Aunit beat valid
// - o_ready      out  1        beat accepted when i_valid & o_ready & !i_stall
// - i_ss         in   SSctl    per-beat control: init, fstpix, lstpix, sht, sht_num
// - i_au_data    in   AUWD     signed partial product
// - i_ppad_rdata in   PSUMDWD  signed psum init value, valid with any beat carrying init
// - o_psum_valid out  1        output psum valid
// - i_psum_ready in   1        downstream accept
// - o_psum       out  PSUMDWD  saturated psum
// - o_row_done   out  1        1-cycle pulse when the i_tw-th psum of a row is accepted downstream
// - o_err        out  1        sticky: beat without init while IDLE
// BEHAVIOUR
// - Reset (async) / i_clear (sync): acc=0, FSM=IDLE, o_psum_valid=0, o_psum=0, pix_cnt=0.
// - Reset (cont.): o_row_done=0, o_err=0; o_ready=1 once reset is released.
// - FSM IDLE->ACC on an accepted init beat without lstpix; ACC->IDLE on an accepted lstpix beat.
// - Beat arithmetic: base = fstpix&init ? 0 : init ? sext(i_ppad_rdata) : acc.
// - Beat arithmetic (cont.): sh = sht ? base <<< (1<<sht_num) : base; acc_next = sh + sext(i_au_data).
// - All arithmetic is two's complement at ACCWD; overflow within ACCWD wraps, not checked.
// - init in ACC: restarts the pixel from base; the previous acc is discarded (no err).
// - Non-init beat in IDLE: o_err<=1; the beat is treated as fstpix&init.
// - lstpix beat: the output register loads sat(acc_next); acc<=0; FSM->IDLE.
// - lstpix+init on the same beat: single-beat pixel, loads sat(base+au).
// - sat clamps to [-2^(PSUMDWD-1), 2^(PSUMDWD-1)-1].
// - Latency: the psum is visible on o_psum_valid 1 cycle after the lstpix beat is accepted.
// - Output register is single-entry; o_ready = !o_psum_valid | i_psum_ready (same-cycle drain+refill allowed).
// - o_ready gates all beats, not only lstpix.
// - o_psum/o_psum_valid hold stable while valid & !ready. i_stall also blocks the downstream handshake.
// - pix_cnt increments on each accepted output; it wraps to 0 at i_tw-1 and pulses o_row_done that cycle.
// - i_tw is latched on the IDLE->ACC transition; changes mid-pixel are ignored.
// STRUCTURE
// - SSctl, ShtNum: PECtlCfg. Add to PECtlCfg: typedef enum {SA_IDLE,SA_ACC} SaState.
// - Add to PECtlCfg: parameter SAACCWD=24.
// - One sub-module, psum_sat (ACCWD->PSUMDWD signed clamp, combinational); the rest is inline.
// TESTING
// - 4 beats, sht=1/SHT1, au=1,0,1,1, first fstpix+init, last lstpix -> o_psum=11, 1 cycle after.
// - init from ppad=100, sht=0, au=-30, lstpix on the same beat -> o_psum=70.
// - Saturation: init ppad=32767, beat sht=1/SHT8, au=0, lstpix -> o_psum=32767.
// - Saturation (cont.): same with ppad=-32768 -> -32768.
// - Backpressure: i_psum_ready=0 with a psum pending -> o_ready=0, o_psum held.
// - Backpressure (cont.): release -> drain and new beat accepted in the same cycle.
// - i_tw=3, 7 single-beat pixels, all ready -> o_row_done pulses on outputs #3 and #6 only.
// - Non-init beat in IDLE -> o_err=1 and sticky until i_clear.
// - i_clear mid-pixel -> o_psum_valid=0, acc=0, o_err=0.
// - i_rst low mid-pixel -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pe_shift_acc_pkg.sv
// Shared types and constants for the PE shift-accumulate stage.
//   sht_num_e  : shift selector; the applied left shift is 1 << sht_num (1, 2, 4 or 8 bits)
//   ss_ctl_t   : per-beat shift-accumulate control word
//   sa_state_e : accumulator FSM state
//   SaAccWd    : default internal accumulator width
package pe_shift_acc_pkg;

    localparam int unsigned SaAccWd = 24;

    typedef enum logic [1:0] {
        Sht1 = 2'd0,
        Sht2 = 2'd1,
        Sht4 = 2'd2,
        Sht8 = 2'd3
    } sht_num_e;

    typedef struct packed {
        logic     init;     // take base from the psum pad (or zero when fstpix)
        logic     fstpix;   // first beat of a pixel: base is zero
        logic     lstpix;   // last beat: emit saturated psum
        logic     sht;      // shift base before adding the partial product
        sht_num_e sht_num;
    } ss_ctl_t;

    typedef enum logic {
        SaIdle,
        SaAcc
    } sa_state_e;

    // Left-shift distance selected by sht_num.
    function automatic logic [3:0] sht_amt(sht_num_e n);
        return 4'd1 << n;
    endfunction

endpackage

// File: rtl/pe_shift_acc_psum_sat.sv
// Combinational signed clamp from an InWd-bit accumulator to an OutWd-bit psum.
//   in_i  : signed accumulator value
//   out_o : value clamped to [-2^(OutWd-1), 2^(OutWd-1)-1]
module psum_sat #(
    parameter int unsigned InWd  = 24,
    parameter int unsigned OutWd = 16
) (
    input  logic signed [InWd-1:0]  in_i,
    output logic signed [OutWd-1:0] out_o
);

    localparam logic signed [InWd-1:0] MaxV = {{(InWd-OutWd+1){1'b0}}, {(OutWd-1){1'b1}}};
    localparam logic signed [InWd-1:0] MinV = {{(InWd-OutWd+1){1'b1}}, {(OutWd-1){1'b0}}};

    always_comb begin
        out_o = in_i[OutWd-1:0];
        if (in_i > MaxV) begin
            out_o = MaxV[OutWd-1:0];
        end else if (in_i < MinV) begin
            out_o = MinV[OutWd-1:0];
        end
    end

endmodule

// File: rtl/pe_shift_acc.sv
// Shift-accumulate stage of the PE datapath. Folds bit-serial Aunit partial products into
// one psum per output pixel and emits it saturated through a single-entry output register.
//   i_clk, i_rst      : clock, asynchronous active-low reset
//   i_clear           : synchronous clear, highest priority
//   i_stall           : freezes all state, blocks both handshakes
//   i_tw              : pixels per row, tracked while idle
//   i_valid/o_ready   : Aunit beat handshake; i_ss/i_au_data/i_ppad_rdata qualify the beat
//   o_psum_valid/i_psum_ready/o_psum : output psum handshake
//   o_row_done        : pulse while the last psum of a row is being accepted downstream
//   o_err             : sticky, set by a beat without init while idle
module pe_shift_acc
    import pe_shift_acc_pkg::*;
#(
    parameter int unsigned ACCWD   = SaAccWd,
    parameter int unsigned PSUMDWD = 16,
    parameter int unsigned AUWD    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_stall,
    input  logic [6:0]         i_tw,
    input  logic               i_valid,
    output logic               o_ready,
    input  ss_ctl_t            i_ss,
    input  logic [AUWD-1:0]    i_au_data,
    input  logic [PSUMDWD-1:0] i_ppad_rdata,
    output logic               o_psum_valid,
    input  logic               i_psum_ready,
    output logic [PSUMDWD-1:0] o_psum,
    output logic               o_row_done,
    output logic               o_err
);

    sa_state_e                 state_q;
    logic signed [ACCWD-1:0]   acc_q;
    logic                      psum_valid_q;
    logic signed [PSUMDWD-1:0] psum_q;
    logic                      err_q;
    logic [6:0]                tw_q;
    logic [6:0]                pix_cnt_q;

    logic                      idle, accept, drain, first, row_wrap;
    logic signed [ACCWD-1:0]   base, sh, acc_next, ppad_ext, au_ext;
    logic signed [PSUMDWD-1:0] sat_out;

    always_comb begin
        idle     = (state_q == SaIdle);
        accept   = i_valid & o_ready & ~i_stall;
        drain    = psum_valid_q & i_psum_ready & ~i_stall;
        // A non-init beat while idle is handled as a fresh pixel starting from zero.
        first    = (i_ss.init & i_ss.fstpix) | (~i_ss.init & idle);
        ppad_ext = {{(ACCWD-PSUMDWD){i_ppad_rdata[PSUMDWD-1]}}, i_ppad_rdata};
        au_ext   = {{(ACCWD-AUWD){i_au_data[AUWD-1]}}, i_au_data};
        if (first) begin
            base = '0;
        end else if (i_ss.init) begin
            base = ppad_ext;
        end else begin
            base = acc_q;
        end
        sh       = i_ss.sht ? (base <<< sht_amt(i_ss.sht_num)) : base;
        acc_next = sh + au_ext;
        row_wrap = (pix_cnt_q == tw_q - 7'd1);
    end

    psum_sat #(
        .InWd  (ACCWD),
        .OutWd (PSUMDWD)
    ) u_psum_sat (
        .in_i  (acc_next),
        .out_o (sat_out)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= SaIdle;
            acc_q        <= '0;
            psum_valid_q <= 1'b0;
            psum_q       <= '0;
            err_q        <= 1'b0;
            tw_q         <= 7'd1;
            pix_cnt_q    <= '0;
        end else if (i_clear) begin
            state_q      <= SaIdle;
            acc_q        <= '0;
            psum_valid_q <= 1'b0;
            psum_q       <= '0;
            err_q        <= 1'b0;
            tw_q         <= 7'd1;
            pix_cnt_q    <= '0;
        end else if (!i_stall) begin
            // Row length only follows i_tw between pixels; it is frozen once a pixel is open.
            if (idle) begin
                tw_q <= i_tw;
            end
            if (drain) begin
                psum_valid_q <= 1'b0;
                pix_cnt_q    <= row_wrap ? 7'd0 : pix_cnt_q + 7'd1;
            end
            // Refill after drain so a same-cycle drain+refill leaves the register valid.
            if (accept) begin
                if (!i_ss.init && idle) begin
                    err_q <= 1'b1;
                end
                if (i_ss.lstpix) begin
                    psum_q       <= sat_out;
                    psum_valid_q <= 1'b1;
                    acc_q        <= '0;
                    state_q      <= SaIdle;
                end else begin
                    acc_q   <= acc_next;
                    state_q <= SaAcc;
                end
            end
        end
    end

    assign o_ready      = ~psum_valid_q | i_psum_ready;
    assign o_psum_valid = psum_valid_q;
    assign o_psum       = psum_q;
    assign o_row_done   = drain & row_wrap;
    assign o_err        = err_q;

endmodule

// File: tb/tb_pe_shift_acc.sv
// Directed self-checking bench for pe_shift_acc. Inputs change on the falling edge and
// outputs are sampled there too, so each check sees the state after the preceding rising edge.
module tb_pe_shift_acc;
    import pe_shift_acc_pkg::*;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_clear;
    logic          i_stall;
    logic [6:0]    i_tw;
    logic          i_valid;
    logic          o_ready;
    ss_ctl_t       i_ss;
    logic [15:0]   i_au_data;
    logic [15:0]   i_ppad_rdata;
    logic          o_psum_valid;
    logic          i_psum_ready;
    logic [15:0]   o_psum;
    logic          o_row_done;
    logic          o_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    pe_shift_acc #(
        .ACCWD   (24),
        .PSUMDWD (16),
        .AUWD    (16)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (i_clear),
        .i_stall      (i_stall),
        .i_tw         (i_tw),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_ss         (i_ss),
        .i_au_data    (i_au_data),
        .i_ppad_rdata (i_ppad_rdata),
        .o_psum_valid (o_psum_valid),
        .i_psum_ready (i_psum_ready),
        .o_psum       (o_psum),
        .o_row_done   (o_row_done),
        .o_err        (o_err)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic init, input logic fst, input logic lst, input logic sht,
                         input sht_num_e n, input int au, input int pp);
        i_valid            = 1'b1;
        i_ss.init          = init;
        i_ss.fstpix        = fst;
        i_ss.lstpix        = lst;
        i_ss.sht           = sht;
        i_ss.sht_num       = n;
        i_au_data          = au[15:0];
        i_ppad_rdata       = pp[15:0];
    endtask

    task automatic no_beat();
        i_valid = 1'b0;
        i_ss    = '0;
    endtask

    task automatic cyc();
        @(negedge i_clk);
    endtask

    function automatic logic signed [31:0] ps();
        return 32'($signed(o_psum));
    endfunction

    initial begin
        i_rst        = 1'b0;
        i_clear      = 1'b0;
        i_stall      = 1'b0;
        i_tw         = 7'd100;
        i_psum_ready = 1'b1;
        i_au_data    = '0;
        i_ppad_rdata = '0;
        no_beat();

        // Reset state
        cyc();
        cyc();
        chk("rst_valid", 32'(o_psum_valid), 0);
        chk("rst_psum", ps(), 0);
        chk("rst_row_done", 32'(o_row_done), 0);
        chk("rst_err", 32'(o_err), 0);
        i_rst = 1'b1;
        cyc();
        chk("rst_ready", 32'(o_ready), 1);

        // Four-beat pixel with shift-by-1: ((1*2+0)*2+1)*2+1 = 11
        drive(1, 1, 0, 1, Sht1, 1, 0);
        cyc();
        drive(0, 0, 0, 1, Sht1, 0, 0);
        cyc();
        drive(0, 0, 0, 1, Sht1, 1, 0);
        cyc();
        drive(0, 0, 1, 1, Sht1, 1, 0);
        chk("acc4_not_yet", 32'(o_psum_valid), 0);
        cyc();
        no_beat();
        chk("acc4_valid", 32'(o_psum_valid), 1);
        chk("acc4_psum", ps(), 11);
        cyc();
        chk("acc4_drained", 32'(o_psum_valid), 0);

        // Single-beat pixel from psum pad: 100 - 30
        drive(1, 0, 1, 0, Sht1, -30, 100);
        cyc();
        no_beat();
        chk("init_ppad", ps(), 70);

        // Positive saturation: 32767 << 8
        drive(1, 0, 1, 1, Sht8, 0, 32767);
        cyc();
        no_beat();
        chk("sat_pos", ps(), 32767);
        // Negative saturation: -32768 << 8
        drive(1, 0, 1, 1, Sht8, 0, -32768);
        cyc();
        no_beat();
        chk("sat_neg", ps(), -32768);
        cyc();

        // Backpressure, then drain and refill on the same edge
        i_psum_ready = 1'b0;
        drive(1, 0, 1, 0, Sht1, 1, 5);
        cyc();
        chk("bp_valid", 32'(o_psum_valid), 1);
        chk("bp_psum", ps(), 6);
        chk("bp_ready_low", 32'(o_ready), 0);
        drive(1, 0, 1, 0, Sht1, 0, 10);
        cyc();
        chk("bp_hold_psum", ps(), 6);
        chk("bp_hold_valid", 32'(o_psum_valid), 1);
        i_psum_ready = 1'b1;
        #1;
        chk("bp_ready_high", 32'(o_ready), 1);
        cyc();
        no_beat();
        chk("bp_refill_valid", 32'(o_psum_valid), 1);
        chk("bp_refill_psum", ps(), 10);
        cyc();
        chk("bp_empty", 32'(o_psum_valid), 0);

        // Stall blocks the beat handshake
        i_stall = 1'b1;
        drive(1, 0, 1, 0, Sht1, 0, 9);
        cyc();
        chk("stall_blocked", 32'(o_psum_valid), 0);
        i_stall = 1'b0;
        cyc();
        no_beat();
        chk("stall_release", ps(), 9);
        cyc();

        // Row tracking: Tw=3, seven single-beat pixels, pulse on outputs 3 and 6
        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0;
        i_tw    = 7'd3;
        cyc();
        for (int j = 1; j <= 7; j++) begin
            drive(1, 0, 1, 0, Sht1, 0, j * 10);
            cyc();
            chk($sformatf("row_psum%0d", j), ps(), j * 10);
            chk($sformatf("row_done%0d", j), 32'(o_row_done), (j == 3 || j == 6) ? 1 : 0);
        end
        no_beat();
        cyc();
        chk("row_done_idle", 32'(o_row_done), 0);

        // Non-init beat while idle: error, and the beat starts a pixel from zero
        drive(0, 0, 0, 0, Sht1, 3, 0);
        cyc();
        chk("err_set", 32'(o_err), 1);
        drive(0, 0, 1, 0, Sht1, 2, 0);
        cyc();
        no_beat();
        chk("err_pixel", ps(), 5);
        cyc();
        cyc();
        chk("err_sticky", 32'(o_err), 1);

        // Clear with a psum pending and the error set
        i_psum_ready = 1'b0;
        drive(1, 0, 1, 0, Sht1, 4, 0);
        cyc();
        no_beat();
        chk("clr_pending", 32'(o_psum_valid), 1);
        i_clear = 1'b1;
        cyc();
        i_clear      = 1'b0;
        i_psum_ready = 1'b1;
        chk("clr_valid", 32'(o_psum_valid), 0);
        chk("clr_psum", ps(), 0);
        chk("clr_err", 32'(o_err), 0);
        chk("clr_ready", 32'(o_ready), 1);

        // Clear mid-pixel discards acc: a following shifted non-init beat sees zero, not 7
        drive(1, 1, 0, 0, Sht1, 7, 0);
        cyc();
        no_beat();
        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0;
        drive(0, 0, 1, 1, Sht1, 1, 0);
        cyc();
        no_beat();
        chk("clr_mid_psum", ps(), 1);
        chk("clr_mid_err", 32'(o_err), 1);
        cyc();

        // Async reset mid-pixel, no clock edge involved
        drive(1, 1, 0, 0, Sht1, 3, 0);
        cyc();
        no_beat();
        #2;
        i_rst = 1'b0;
        #1;
        chk("arst_valid", 32'(o_psum_valid), 0);
        chk("arst_psum", ps(), 0);
        chk("arst_err", 32'(o_err), 0);
        chk("arst_row_done", 32'(o_row_done), 0);
        cyc();
        i_rst = 1'b1;
        drive(0, 0, 1, 0, Sht1, 2, 0);
        cyc();
        no_beat();
        chk("arst_idle_psum", ps(), 2);
        chk("arst_idle_err", 32'(o_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
